// File: rtl/seven_seg_reader.sv
// Recovers hex digits from a multiplexed active-low seven-segment bus.
// Each digit is captured once per stable window and reported with a one-cycle update strobe.
module seven_seg_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   blank_out,
  output logic [NUM_DIGITS-1:0]   err_out,
  output logic                    upd_valid,
  output logic [2:0]              upd_idx,
  output logic [3:0]              upd_value
);

  localparam int         SW     = NUM_DIGITS + 7;
  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  // Returns {recognised, value}; exact match against the decoder's glyph table.
  function automatic logic [4:0] seg_encode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b1000000: r = {1'b1, 4'h0};
      7'b1001111: r = {1'b1, 4'h1};
      7'b0100100: r = {1'b1, 4'h2};
      7'b0110000: r = {1'b1, 4'h3};
      7'b0011001: r = {1'b1, 4'h4};
      7'b0010010: r = {1'b1, 4'h5};
      7'b0000010: r = {1'b1, 4'h6};
      7'b1111000: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0011000: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b0000011: r = {1'b1, 4'hB};
      7'b0100111: r = {1'b1, 4'hC};
      7'b0100001: r = {1'b1, 4'hD};
      7'b0000110: r = {1'b1, 4'hE};
      7'b0001110: r = {1'b1, 4'hF};
      default:    r = 5'b0;
    endcase
    return r;
  endfunction

  logic [SW-1:0]           samp_q, samp_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d, blank_q, blank_d, err_q, err_d;
  logic                    upd_valid_q, upd_valid_d;
  logic [2:0]              upd_idx_q, upd_idx_d;
  logic [3:0]              upd_value_q, upd_value_d;

  logic [3:0] zeros;
  logic [2:0] sel_idx;
  logic       legal, same, capture, is_blank;
  logic [4:0] enc;

  always_comb begin
    zeros   = 4'd0;
    sel_idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_in[i]) begin
        zeros   = zeros + 4'd1;
        sel_idx = 3'(i);
      end
    end
    legal    = (zeros == 4'd1);
    samp_d   = {an_in, seg_in};
    same     = (samp_q == samp_d);
    enc      = seg_encode(seg_in);
    is_blank = (seg_in == 7'b1111111);

    if (!legal)               cnt_d = 4'd0;
    else if (!same)           cnt_d = 4'd1;
    else if (cnt_q < STABLE)  cnt_d = cnt_q + 4'd1;
    else                      cnt_d = cnt_q;

    // The edge where cnt reaches STABLE is the only capture point of a window.
    capture = legal && same && (cnt_q == STABLE - 4'd1);

    digits_d    = digits_q;
    valid_d     = valid_q;
    blank_d     = blank_q;
    err_d       = err_q;
    upd_valid_d = 1'b0;
    upd_idx_d   = upd_idx_q;
    upd_value_d = upd_value_q;

    if (clear) begin
      cnt_d    = 4'd0;
      digits_d = '0;
      valid_d  = '0;
      blank_d  = '0;
      err_d    = '0;
    end else if (capture) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (sel_idx == 3'(i)) begin
          if (enc[4]) begin
            digits_d[4*i +: 4] = enc[3:0];
            valid_d[i]         = 1'b1;
            blank_d[i]         = 1'b0;
            err_d[i]           = 1'b0;
          end else if (is_blank) begin
            blank_d[i] = 1'b1;
            err_d[i]   = 1'b0;
          end else begin
            err_d[i]   = 1'b1;
            blank_d[i] = 1'b0;
          end
        end
      end
      if (enc[4]) begin
        upd_valid_d = 1'b1;
        upd_idx_d   = sel_idx;
        upd_value_d = enc[3:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q      <= '0;
      cnt_q       <= 4'd0;
      digits_q    <= '0;
      valid_q     <= '0;
      blank_q     <= '0;
      err_q       <= '0;
      upd_valid_q <= 1'b0;
      upd_idx_q   <= 3'd0;
      upd_value_q <= 4'd0;
    end else begin
      samp_q      <= samp_d;
      cnt_q       <= cnt_d;
      digits_q    <= digits_d;
      valid_q     <= valid_d;
      blank_q     <= blank_d;
      err_q       <= err_d;
      upd_valid_q <= upd_valid_d;
      upd_idx_q   <= upd_idx_d;
      upd_value_q <= upd_value_d;
    end
  end

  assign digits_out  = digits_q;
  assign digit_valid = valid_q;
  assign blank_out   = blank_q;
  assign err_out     = err_q;
  assign upd_valid   = upd_valid_q;
  assign upd_idx     = upd_idx_q;
  assign upd_value   = upd_value_q;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Directed bench for seven_seg_reader with NUM_DIGITS=4, STABLE_CYCLES=4.
module tb_seven_seg_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic        clear;
  logic [15:0] digits_out;
  logic [3:0]  digit_valid, blank_out, err_out;
  logic        upd_valid;
  logic [2:0]  upd_idx;
  logic [3:0]  upd_value;

  int total = 0;
  int bad   = 0;
  int npulse;
  logic [3:0] vals[$];
  logic [2:0] last_idx;

  logic [6:0] glyphs [16] = '{7'b1000000, 7'b1001111, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                              7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110};

  seven_seg_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in), .clear(clear),
    .digits_out(digits_out), .digit_valid(digit_valid), .blank_out(blank_out),
    .err_out(err_out), .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_value(upd_value)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a pattern, advance n edges and record every update pulse seen.
  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_in  = an;
    seg_in = seg;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (upd_valid) begin
        npulse++;
        last_idx = upd_idx;
        vals.push_back(upd_value);
      end
    end
  endtask

  task automatic reset_pulses();
    npulse = 0;
    vals.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dig"},   32'(digits_out),  32'h0);
    chk({tag, "_vld"},   32'(digit_valid), 32'h0);
    chk({tag, "_blank"}, 32'(blank_out),   32'h0);
    chk({tag, "_err"},   32'(err_out),     32'h0);
    chk({tag, "_upd"},   32'(upd_valid),   32'h0);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; an_in = 4'b1111; seg_in = 7'b1111111;
    last_idx = 3'd0;
    reset_pulses();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Basic capture of 3 on digit 0
    hold(4'b1110, 7'b0110000, 3);
    chk("pre_cap_pulse", 32'(npulse), 32'd0);
    hold(4'b1110, 7'b0110000, 1);
    chk("cap3_pulse", 32'(npulse), 32'd1);
    chk("cap3_idx",   32'(last_idx), 32'd0);
    chk("cap3_val",   32'(vals[0]), 32'd3);
    chk("cap3_dig",   32'(digits_out[3:0]), 32'd3);
    chk("cap3_vld",   32'(digit_valid), 32'b0001);

    // Scan all 16 glyphs on digit 2
    reset_pulses();
    for (int g = 0; g < 16; g++) hold(4'b1011, glyphs[g], 4);
    chk("scan_pulses", 32'(npulse), 32'd16);
    for (int g = 0; g < 16 && g < vals.size(); g++) chk("scan_val", 32'(vals[g]), 32'(g));
    chk("scan_idx",   32'(last_idx), 32'd2);
    chk("scan_err",   32'(err_out), 32'h0);
    chk("scan_blank", 32'(blank_out), 32'h0);
    chk("scan_dig",   32'(digits_out), 32'h0F03);
    chk("scan_vld",   32'(digit_valid), 32'b0101);

    // Three-cycle hold is filtered
    reset_pulses();
    hold(4'b1101, 7'b0100100, 3);
    hold(4'b1111, 7'b0100100, 1);
    chk("short_pulse", 32'(npulse), 32'd0);
    chk("short_dig",   32'(digits_out), 32'h0F03);
    chk("short_vld",   32'(digit_valid), 32'b0101);

    // Digit 1: 5, then dash (error), then blank
    reset_pulses();
    hold(4'b1101, 7'b0010010, 4);
    chk("d1_pulse", 32'(npulse), 32'd1);
    chk("d1_dig",   32'(digits_out[7:4]), 32'd5);
    hold(4'b1101, 7'b0111111, 4);
    chk("dash_pulse", 32'(npulse), 32'd1);
    chk("dash_err",   32'(err_out), 32'b0010);
    chk("dash_dig",   32'(digits_out[7:4]), 32'd5);
    chk("dash_vld",   32'(digit_valid[1]), 32'd1);
    hold(4'b1101, 7'b1111111, 4);
    chk("blank_pulse", 32'(npulse), 32'd1);
    chk("blank_b",     32'(blank_out), 32'b0010);
    chk("blank_err",   32'(err_out), 32'b0000);
    chk("blank_dig",   32'(digits_out[7:4]), 32'd5);

    // Illegal anode never captures; long legal hold captures once
    reset_pulses();
    hold(4'b1100, 7'b0000000, 10);
    chk("illegal_pulse", 32'(npulse), 32'd0);
    hold(4'b0111, 7'b0000000, 20);
    chk("long_pulse", 32'(npulse), 32'd1);
    chk("long_idx",   32'(last_idx), 32'd3);
    chk("long_val",   32'(vals[0]), 32'd8);
    chk("long_dig",   32'(digits_out), 32'h8F53);

    // Clear on the capture edge drops the capture
    reset_pulses();
    hold(4'b1110, 7'b1001111, 3);
    clear = 1'b1;
    hold(4'b1110, 7'b1001111, 1);
    clear = 1'b0;
    chk("clr_pulse", 32'(npulse), 32'd0);
    chk_all_zero("clr");
    hold(4'b1110, 7'b1001111, 3);
    chk("clr_recap_early", 32'(npulse), 32'd0);
    hold(4'b1110, 7'b1001111, 1);
    chk("clr_recap", 32'(npulse), 32'd1);
    chk("clr_recap_dig", 32'(digits_out), 32'h0001);

    // Async reset mid-window aborts it
    reset_pulses();
    hold(4'b1011, 7'b0011001, 2);
    rst_n = 1'b0;
    #1;
    chk_all_zero("areset");
    #2;
    rst_n = 1'b1;
    hold(4'b1011, 7'b0011001, 3);
    chk("areset_early", 32'(npulse), 32'd0);
    hold(4'b1011, 7'b0011001, 1);
    chk("areset_cap",   32'(npulse), 32'd1);
    chk("areset_dig",   32'(digits_out), 32'h0400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
